// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding and
// the width helper used to size the cycle counter.
package rst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_DONE    = 2'b10,
        ST_SWRST   = 2'b11
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_sequencer_pulse_gen.sv
// Rising-edge detector for the software reset request: one registered copy
// of the request, the pulse is high on the cycle the request first rises.
module pulse_gen (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    output logic o_pulse
);

    logic r_req_d;

    // Delayed copy of the request, sampled every cycle in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= i_req;
        end
    end

    assign o_pulse = i_req & ~r_req_d;

endmodule

// File: rtl/rst_sequencer.sv
// Releases NUM_OUT active-low block resets one at a time after a power-on
// hold, and re-runs the sequence on a software reset request.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_OUT      = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int SWRST_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               seq_done,
    output logic               busy
);

    localparam int CW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, SWRST_CYCLES) + 1);
    localparam int IW = $clog2(NUM_OUT + 1);

    localparam logic [CW-1:0]      HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]      GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]      SWRST_LAST = CW'(SWRST_CYCLES - 1);
    localparam logic [IW-1:0]      IDX_LAST   = IW'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] OUT_ONE    = NUM_OUT'(1);

    seq_state_e         r_state;
    seq_state_e         w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nx;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idx_nx;
    logic [NUM_OUT-1:0] r_rst_out;
    logic [NUM_OUT-1:0] w_rst_out_nx;
    logic               r_seq_done;
    logic               w_done_nx;
    logic               w_trig;

    pulse_gen u_pulse_gen (
        .clk     (clk),
        .rst     (rst),
        .i_req   (sw_rst_req),
        .o_pulse (w_trig)
    );

    // Next-state, counter, release index and output decisions
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + CW'(1);
        w_idx_nx     = r_idx;
        w_rst_out_nx = r_rst_out;
        w_done_nx    = r_seq_done;
        case (r_state)
            ST_HOLD, ST_SWRST: begin
                if (((r_state == ST_HOLD) && (r_cnt == HOLD_LAST)) ||
                    ((r_state == ST_SWRST) && (r_cnt == SWRST_LAST))) begin
                    w_rst_out_nx = OUT_ONE;
                    w_idx_nx     = IW'(1);
                    w_cnt_nx     = '0;
                    if (NUM_OUT == 1) begin
                        w_state_nx = ST_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_RELEASE;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == GAP_LAST) begin
                    w_rst_out_nx = r_rst_out | (OUT_ONE << r_idx);
                    w_cnt_nx     = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = ST_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + IW'(1);
                    end
                end else begin
                    w_state_nx = ST_RELEASE;
                end
            end
            ST_DONE: begin
                w_cnt_nx = '0;
                // Only a fresh rising edge of the request re-runs the sequence
                if (w_trig) begin
                    w_rst_out_nx = '0;
                    w_done_nx    = 1'b0;
                    w_idx_nx     = '0;
                    w_state_nx   = ST_SWRST;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx   = ST_HOLD;
                w_cnt_nx     = '0;
                w_idx_nx     = '0;
                w_rst_out_nx = '0;
                w_done_nx    = 1'b0;
            end
        endcase
    end

    // State, counter, index and output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_rst_out  <= w_rst_out_nx;
            r_seq_done <= w_done_nx;
        end
    end

    assign rst_out  = r_rst_out;
    assign seq_done = r_seq_done;
    assign busy     = (r_state != ST_DONE);

endmodule
